// File: rtl/branch_update_queue.sv
// In-order retirement queue for predicted branches: tracks each branch from fetch
// to resolution, drives the predictor update port and repairs history on mispredict.
module branch_update_queue #(
    parameter int HISTORY_LEN = 8,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    input  logic [15:0]            alloc_pc,
    input  logic [HISTORY_LEN-1:0] alloc_history,
    input  logic                   alloc_prediction,
    output logic                   alloc_ready,
    output logic [TAG_W-1:0]       alloc_tag,
    input  logic                   resolve_valid,
    input  logic [TAG_W-1:0]       resolve_tag,
    input  logic                   resolve_outcome,
    output logic                   write_enabled,
    output logic [15:0]            pc_bits_write,
    output logic [HISTORY_LEN-1:0] history_write,
    output logic                   outcome,
    output logic                   mispredict,
    output logic [HISTORY_LEN-1:0] repair_history,
    output logic [TAG_W:0]         count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    logic                   ent_valid      [DEPTH];
    logic                   ent_resolved   [DEPTH];
    logic [15:0]            ent_pc         [DEPTH];
    logic [HISTORY_LEN-1:0] ent_history    [DEPTH];
    logic                   ent_prediction [DEPTH];
    logic                   ent_outcome    [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W-1:0] head_inc;
    logic             alloc_accept;
    logic             resolve_hit;
    logic             retire;
    logic             retire_mis;
    logic [TAG_W:0]   count_next;

    assign alloc_ready = (count != FULL_COUNT);
    assign alloc_tag   = tail;
    assign head_inc    = head + TAG_W'(1);

    always_comb begin
        alloc_accept = alloc_valid & alloc_ready;
        resolve_hit  = resolve_valid & ent_valid[resolve_tag] & ~ent_resolved[resolve_tag];
        retire       = ent_valid[head] & ent_resolved[head];
        retire_mis   = retire & (ent_prediction[head] != ent_outcome[head]);
        count_next   = count;
        if (alloc_accept && !retire) begin
            count_next = count + (TAG_W+1)'(1);
        end else if (retire && !alloc_accept) begin
            count_next = count - (TAG_W+1)'(1);
        end
    end

    // A mispredict flushes everything younger than the retiring branch, so the
    // same-cycle allocation and resolve are dropped and the queue restarts empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            write_enabled  <= 1'b0;
            mispredict     <= 1'b0;
            pc_bits_write  <= '0;
            history_write  <= '0;
            outcome        <= 1'b0;
            repair_history <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i]      <= 1'b0;
                ent_resolved[i]   <= 1'b0;
                ent_pc[i]         <= '0;
                ent_history[i]    <= '0;
                ent_prediction[i] <= 1'b0;
                ent_outcome[i]    <= 1'b0;
            end
        end else begin
            write_enabled <= retire;
            mispredict    <= retire_mis;
            if (retire) begin
                pc_bits_write <= ent_pc[head];
                history_write <= ent_history[head];
                outcome       <= ent_outcome[head];
            end
            if (retire_mis) begin
                repair_history <= {ent_history[head][HISTORY_LEN-2:0], ent_outcome[head]};
                head           <= head_inc;
                tail           <= head_inc;
                count          <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_valid[i]    <= 1'b0;
                    ent_resolved[i] <= 1'b0;
                end
            end else begin
                if (retire) begin
                    ent_valid[head]    <= 1'b0;
                    ent_resolved[head] <= 1'b0;
                    head               <= head_inc;
                end
                if (alloc_accept) begin
                    ent_valid[tail]      <= 1'b1;
                    ent_resolved[tail]   <= 1'b0;
                    ent_pc[tail]         <= alloc_pc;
                    ent_history[tail]    <= alloc_history;
                    ent_prediction[tail] <= alloc_prediction;
                    tail                 <= tail + TAG_W'(1);
                end
                if (resolve_hit) begin
                    ent_resolved[resolve_tag] <= 1'b1;
                    ent_outcome[resolve_tag]  <= resolve_outcome;
                end
                count <= count_next;
            end
        end
    end

endmodule
